// File: rtl/covert_tx_scheduler.sv
// Frame sequencer for the antenna covert channel: preamble + data byte, one bit per slot, one MMCM window per slot.
// Latency: first slot starts the cycle after acceptance; tx_ready is only high in IDLE, so bytes wait while a frame runs.
module covert_tx_scheduler #(
   parameter int          BIT_CYCLES   = 1000000,
   parameter int          GUARD_CYCLES = 1000,
   parameter logic [7:0]  PREAMBLE     = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       antenna_en,
   output logic       meas_start,
   input  logic       meas_done,
   output logic       busy,
   output logic       frame_done,
   output logic [7:0] timeout_cnt
);

   localparam int MAXC = (BIT_CYCLES > GUARD_CYCLES) ? BIT_CYCLES : GUARD_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;

   typedef enum logic [1:0] {IDLE, BIT, GUARD, DONE} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [15:0]   shift_reg, shift_n;
   logic [3:0]    bit_idx, bit_idx_n;
   logic          seen, seen_n;
   logic [7:0]    tcnt_n;
   logic          ant_n, ms_n;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      shift_n   = shift_reg;
      bit_idx_n = bit_idx;
      seen_n    = seen;
      tcnt_n    = timeout_cnt;
      case (state)
         IDLE: begin
            if (enable && tx_valid) begin
               shift_n   = {PREAMBLE, tx_data};
               bit_idx_n = 4'd15;
               cnt_n     = '0;
               seen_n    = 1'b0;
               state_n   = BIT;
            end
         end
         BIT: begin
            seen_n = seen | meas_done;
            if (cnt == CW'(BIT_CYCLES - 1)) begin
               cnt_n   = '0;
               state_n = GUARD;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         GUARD: begin
            seen_n = seen | meas_done;
            if (cnt == CW'(GUARD_CYCLES - 1)) begin
               cnt_n = '0;
               // meas_done arriving on the very last guard cycle still counts as seen
               if (!(seen | meas_done) && timeout_cnt != 8'hFF)
                  tcnt_n = timeout_cnt + 8'd1;
               if (bit_idx == 4'd0) begin
                  state_n = DONE;
               end else begin
                  shift_n   = {shift_reg[14:0], 1'b0};
                  bit_idx_n = bit_idx - 4'd1;
                  seen_n    = 1'b0;
                  state_n   = BIT;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // Abort discards the partial slot, so no timeout is charged for it
      if (!enable && state != IDLE) begin
         state_n = IDLE;
         cnt_n   = '0;
         tcnt_n  = timeout_cnt;
      end
      ant_n = (state_n == BIT) && shift_n[15];
      ms_n  = (state_n == BIT) && (state != BIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         shift_reg   <= '0;
         bit_idx     <= '0;
         seen        <= 1'b0;
         timeout_cnt <= '0;
         antenna_en  <= 1'b0;
         meas_start  <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         shift_reg   <= shift_n;
         bit_idx     <= bit_idx_n;
         seen        <= seen_n;
         timeout_cnt <= tcnt_n;
         antenna_en  <= ant_n;
         meas_start  <= ms_n;
      end
   end

   assign tx_ready   = (state == IDLE) && enable;
   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE) && enable;

endmodule

// File: tb/tb_covert_tx_scheduler.sv
// Bench for covert_tx_scheduler: frame-offset reference model compared every cycle, plus literal frame checks.
module tb_covert_tx_scheduler;
   localparam int BC   = 4;
   localparam int GC   = 2;
   localparam int SLOT = BC + GC;
   localparam int FLEN = 16 * SLOT;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       antenna_en;
   logic       meas_start;
   logic       meas_done;
   logic       busy;
   logic       frame_done;
   logic [7:0] timeout_cnt;

   int checks = 0;
   int errors = 0;

   covert_tx_scheduler #(.BIT_CYCLES(BC), .GUARD_CYCLES(GC), .PREAMBLE(8'hA5)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .antenna_en(antenna_en), .meas_start(meas_start), .meas_done(meas_done),
      .busy(busy), .frame_done(frame_done), .timeout_cnt(timeout_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: a frame is just an offset into a 16-slot schedule.
   bit          mbusy = 1'b0;
   int          moff = 0;
   logic [15:0] mbits = '0;
   bit          mseen = 1'b0;
   int          mto = 0;
   int          cycnum = 0;
   int          t0 = 0;
   int          md_mode = 0;

   always @(posedge clk) cycnum <= cycnum + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mbusy <= 1'b0;
         moff  <= 0;
         mseen <= 1'b0;
         mto   <= 0;
      end else if (mbusy) begin
         if (!enable || moff == FLEN) begin
            mbusy <= 1'b0;
         end else begin
            moff <= moff + 1;
            if (moff % SLOT == SLOT - 1) begin
               mseen <= 1'b0;
               if (!(mseen || meas_done) && mto < 255) mto <= mto + 1;
            end else begin
               mseen <= mseen || meas_done;
            end
         end
      end else if (enable && tx_valid) begin
         mbusy <= 1'b1;
         moff  <= 0;
         mbits <= {8'hA5, tx_data};
         mseen <= 1'b0;
         t0    <= cycnum + 1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Per-cycle compare plus frame observations used by the literal checks.
   logic [15:0] cap = '0;
   int          ms_cnt = 0;
   int          fd_edge = -1000;
   int          last_fd = -1000;
   int          gap = -1;

   always @(negedge clk) begin
      bit in_bits;
      in_bits = mbusy && moff < FLEN;
      check("busy", busy, mbusy);
      check("antenna_en", antenna_en, in_bits && (moff % SLOT) < BC && mbits[15 - moff / SLOT]);
      check("meas_start", meas_start, in_bits && (moff % SLOT) == 0);
      check("frame_done", frame_done, mbusy && moff == FLEN && enable);
      check("tx_ready", tx_ready, !mbusy && enable);
      check("timeout_cnt", timeout_cnt, mto);
      if (in_bits && (moff % SLOT) == 1) cap <= {cap[14:0], antenna_en};
      if (meas_start) ms_cnt <= ms_cnt + 1;
      if (frame_done) begin
         fd_edge <= cycnum;
         last_fd <= cycnum;
      end
      if (meas_start && mbusy && moff == 0) gap <= cycnum - last_fd;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      case (md_mode)
         0: meas_done = 1'b0;
         1: meas_done = mbusy && moff < FLEN && (moff % SLOT) == 2;
         3: meas_done = mbusy && moff < FLEN && (moff % SLOT) == SLOT - 1;
         4: meas_done = !mbusy;
         default: meas_done = ($urandom_range(0, 3) == 0);
      endcase
   endtask

   task automatic run_frame(input logic [7:0] d);
      tx_valid = 1'b1;
      tx_data  = d;
      cyc();
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      for (int i = 0; i < 200 && mbusy; i++) cyc();
      check("frame_end_bound", mbusy, 0);
   endtask

   initial begin
      int ms0;
      rst_n = 1'b0; enable = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; meas_done = 1'b0;
      repeat (2) cyc();
      check("rst_busy", busy, 0);
      check("rst_antenna", antenna_en, 0);
      check("rst_timeout", timeout_cnt, 0);
      check("rst_ready_low", tx_ready, 0);
      enable = 1'b1;
      #1;
      check("rst_ready_follows", tx_ready, 1);
      cyc();
      rst_n = 1'b1;
      cyc();

      // Async reset inside the first BIT cycle
      md_mode = 1;
      tx_valid = 1'b1; tx_data = 8'h3C;
      cyc();
      tx_valid = 1'b0;
      check("first_bit_ant", antenna_en, 1);
      check("first_bit_ms", meas_start, 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_ant", antenna_en, 0);
      check("async_rst_ms", meas_start, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_to", timeout_cnt, 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // Single frame with measurement completing every slot
      ms0 = ms_cnt;
      run_frame(8'h3C);
      check("pattern_3C", cap, 16'hA53C);
      check("ms_pulses", ms_cnt - ms0, 16);
      check("fd_latency", fd_edge - t0 + 1, 97);
      check("to_after_ok", timeout_cnt, 0);

      // meas_done only on each slot's last guard cycle still counts
      md_mode = 3;
      run_frame(8'h5A);
      check("pattern_5A", cap, 16'hA55A);
      check("to_last_guard", timeout_cnt, 0);

      // meas_done only while idle is ignored: every slot times out
      md_mode = 4;
      run_frame(8'h3C);
      check("to_idle_only", timeout_cnt, 16);

      md_mode = 0;
      for (int f = 0; f < 16; f++) run_frame(8'($urandom));
      check("to_saturate", timeout_cnt, 255);

      // Abort during slot 5 BIT
      md_mode = 1;
      tx_valid = 1'b1; tx_data = 8'hF0;
      cyc();
      tx_valid = 1'b0;
      for (int i = 0; i < 100 && !(mbusy && moff == 5 * SLOT + 1); i++) cyc();
      check("abort_reached", moff, 5 * SLOT + 1);
      enable = 1'b0;
      cyc();
      check("abort_ant", antenna_en, 0);
      check("abort_busy", busy, 0);
      check("abort_ready", tx_ready, 0);
      cyc();
      enable = 1'b1;
      #1;
      check("reen_ready", tx_ready, 1);
      run_frame(8'h81);
      check("pattern_after_abort", cap, 16'hA581);

      // tx_valid held with data changing every cycle: back-to-back frames
      tx_valid = 1'b1;
      for (int i = 0; i < 3 * (FLEN + 2) + 5; i++) begin
         tx_data = 8'($urandom);
         cyc();
      end
      tx_valid = 1'b0;
      check("b2b_gap", gap, 2);
      for (int i = 0; i < 200 && mbusy; i++) cyc();
      check("b2b_end_bound", mbusy, 0);

      // Random traffic from a clean counter
      #1 rst_n = 1'b0;
      #1;
      check("rst2_to", timeout_cnt, 0);
      cyc();
      rst_n = 1'b1;
      md_mode = 2;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 149) == 0) enable = 1'b0;
         else if (!enable && $urandom_range(0, 2) == 0) enable = 1'b1;
         tx_valid = ($urandom_range(0, 1) == 1);
         tx_data  = 8'($urandom);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
